// File: rtl/bob_alloc_arb.sv
// bob_alloc_arb: shares the single BOB allocation port between two thread front-ends.
// Latency: grant/ack are combinational (0 cycles); occupancy, rr and flush state update next cycle.
// Backpressure: a grant is accepted only with ~stall & ~doStall; requesters hold req until ack.
//
// Optional feature macro: BOB_ARB_STARVE_EN (per-thread wait counters force tie priority
// for a thread that has waited STARVE_MAX cycles; the STARVE_MAX parameter exists only then).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req0/req1             per-thread allocation requests (held until acked)
//   ack0/ack1, ack_addr   accepted allocation and its BOB entry index (0 when nothing accepted)
//   new_en/new_thread     allocation request towards bob_addr
//   alloc_addr            entry index offered by bob_addr
//   stall, doStall        global stall / BOB full; either one blocks acceptance
//   doRetire/retire_thread one entry retires from the given thread
//   except/except_thread/except_both  flush one or both threads
//   cnt0/cnt1             per-thread occupancy
//   flushing              high while allocation is blocked after an exception
module bob_alloc_arb #(
    parameter int THR_LIMIT  = 32,
    parameter int FLUSH_CYC  = 3
`ifdef BOB_ARB_STARVE_EN
    ,
    parameter int STARVE_MAX = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       ack0,
    output logic       ack1,
    output logic [5:0] ack_addr,
    output logic       new_en,
    output logic       new_thread,
    input  logic [5:0] alloc_addr,
    input  logic       stall,
    input  logic       doStall,
    input  logic       doRetire,
    input  logic       retire_thread,
    input  logic       except,
    input  logic       except_thread,
    input  logic       except_both,
    output logic [5:0] cnt0,
    output logic [5:0] cnt1,
    output logic       flushing
);

    localparam logic [5:0] LIMIT      = 6'(THR_LIMIT);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] flush_cnt;
    logic       rr;          // thread accepted last; the other thread wins the next tie
    logic       elig0;
    logic       elig1;
    logic       tie_thread;
    logic       acc;
    logic       ret0;
    logic       ret1;
    logic       clr0;
    logic       clr1;

    function automatic logic [5:0] step_cnt(input logic [5:0] c, input logic inc,
                                            input logic dec);
        logic [5:0] n;
        n = c;
        if (inc && !dec) begin
            n = c + 6'd1;
        end else if (dec && !inc && c != 6'd0) begin
            n = c - 6'd1;
        end
        return n;
    endfunction

`ifdef BOB_ARB_STARVE_EN
    logic [3:0] wait0;
    logic [3:0] wait1;
    logic       starved0;
    logic       starved1;

    assign starved0 = (wait0 >= 4'(STARVE_MAX));
    assign starved1 = (wait1 >= 4'(STARVE_MAX));
    // A starved thread beats rr; thread 0 wins when both are starved.
    assign tie_thread = starved0 ? 1'b0 : (starved1 ? 1'b1 : ~rr);

    // Waits count only cycles where the thread was eligible but lost; they saturate at 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait0 <= '0;
            wait1 <= '0;
        end else begin
            if (ack0 || except) begin
                wait0 <= '0;
            end else if (elig0 && wait0 != 4'hF) begin
                wait0 <= wait0 + 4'd1;
            end
            if (ack1 || except) begin
                wait1 <= '0;
            end else if (elig1 && wait1 != 4'hF) begin
                wait1 <= wait1 + 4'd1;
            end
        end
    end
`else
    assign tie_thread = ~rr;
`endif

    // Grant path. The except term keeps any allocation from racing the flush.
    always_comb begin
        elig0      = ~rst & req0 & (cnt0 < LIMIT) & (state == RUN) & ~except;
        elig1      = ~rst & req1 & (cnt1 < LIMIT) & (state == RUN) & ~except;
        new_en     = elig0 | elig1;
        new_thread = (elig0 & elig1) ? tie_thread : elig1;
    end

    assign acc      = new_en & ~stall & ~doStall;
    assign ack0     = acc & ~new_thread;
    assign ack1     = acc & new_thread;
    assign ack_addr = acc ? alloc_addr : 6'd0;
    assign flushing = (state == FLUSH);

    assign ret0 = doRetire & ~retire_thread;
    assign ret1 = doRetire & retire_thread;
    assign clr0 = except & (except_both | ~except_thread);
    assign clr1 = except & (except_both | except_thread);

    // Flush window: FLUSH_CYC cycles of FLUSH after the last except.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else if (except) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
        end else if (state == FLUSH) begin
            if (flush_cnt == 3'd0) begin
                state <= RUN;
            end else begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

    // Occupancy; a flush of a thread overrides that thread's same-cycle alloc/retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= clr0 ? 6'd0 : step_cnt(cnt0, ack0, ret0);
            cnt1 <= clr1 ? 6'd0 : step_cnt(cnt1, ack1, ret1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b1;
        end else if (acc) begin
            rr <= new_thread;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && ret0 && !ack0 && cnt0 == 6'd0) begin
            $error("bob_alloc_arb: retire of thread 0 with zero occupancy");
        end
        if (!rst && ret1 && !ack1 && cnt1 == 6'd0) begin
            $error("bob_alloc_arb: retire of thread 1 with zero occupancy");
        end
    end
`endif

endmodule
